// File: rtl/parking_pkg.sv
// Shared types and constants for the parking lot occupancy counter.
`timescale 1ns/1ps
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        ERR  = 3'd7
    } state_e;

    localparam int MAX_COUNT_DEF = 25;
    localparam int CNT_W_DEF     = 5;

    // Sensor codes written as {a, b}: a is the outer beam, b the inner beam.
    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_OUT  = 2'b10;
    localparam logic [1:0] S_BOTH = 2'b11;
    localparam logic [1:0] S_IN   = 2'b01;

endpackage

// File: rtl/sensor_sync.sv
// Multi-flop synchronizer for one asynchronous photo-sensor input.
`timescale 1ns/1ps
module sensor_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/parking_lot_counter.sv
// Gate sensor sequence decoder with a saturating occupancy count and full/empty flags.
`timescale 1ns/1ps
module parking_lot_counter
    import parking_pkg::*;
#(
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic             enter,
    output logic             exit,
    output logic             full,
    output logic             empty,
    output logic             seq_err,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic a_s;
    logic b_s;
    logic [1:0] ab;

    sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (a),
        .q_o    (a_s)
    );

    sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (b),
        .q_o    (b_s)
    );

    assign ab = {a_s, b_s};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enter_q, enter_d;
    logic             exit_q, exit_d;
    logic             seq_err_q, seq_err_d;
    logic             full_q, empty_q;

    always_comb begin
        state_d   = state_q;
        enter_d   = 1'b0;
        exit_d    = 1'b0;
        seq_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                case (ab)
                    S_OUT:   state_d = EN1;
                    S_IN:    state_d = EX1;
                    S_BOTH:  begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            EN1: begin
                case (ab)
                    S_BOTH:  state_d = EN2;
                    S_NONE:  state_d = IDLE;
                    S_IN:    begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            EN2: begin
                case (ab)
                    S_IN:    state_d = EN3;
                    S_OUT:   state_d = EN1;
                    S_NONE:  begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            EN3: begin
                case (ab)
                    S_NONE:  begin state_d = IDLE; enter_d = 1'b1; end
                    S_BOTH:  state_d = EN2;
                    S_OUT:   begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            // Exit path: same shape as the entry path with the sensors swapped.
            EX1: begin
                case (ab)
                    S_BOTH:  state_d = EX2;
                    S_NONE:  state_d = IDLE;
                    S_OUT:   begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            EX2: begin
                case (ab)
                    S_OUT:   state_d = EX3;
                    S_IN:    state_d = EX1;
                    S_NONE:  begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            EX3: begin
                case (ab)
                    S_NONE:  begin state_d = IDLE; exit_d = 1'b1; end
                    S_BOTH:  state_d = EX2;
                    S_IN:    begin state_d = ERR; seq_err_d = 1'b1; end
                    default: ;
                endcase
            end
            ERR: begin
                if (ab == S_NONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturate at both ends; the strobes still fire when the count holds.
        count_d = count_q;
        if (enter_d && (count_q != MAX_C)) begin
            count_d = count_q + CNT_W'(1);
        end else if (exit_d && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            enter_q   <= 1'b0;
            exit_q    <= 1'b0;
            seq_err_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            enter_q   <= enter_d;
            exit_q    <= exit_d;
            seq_err_q <= seq_err_d;
            // Flags come from the next count so they change on the same edge.
            full_q    <= (count_d == MAX_C);
            empty_q   <= (count_d == '0);
        end
    end

    assign count     = count_q;
    assign enter     = enter_q;
    assign exit      = exit_q;
    assign seq_err   = seq_err_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_parking_lot_counter.sv
// Directed bench for parking_lot_counter with a path-walking reference model.
`timescale 1ns/1ps
module tb_parking_lot_counter;
  import parking_pkg::*;

  localparam int MAXC = 25;
  localparam int CW   = 5;
  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic [CW-1:0] count;
  logic enter, exit_p, full, empty, seq_err;
  state_e dbg_state;

  always #5 clk = ~clk;

  parking_lot_counter #(.MAX_COUNT(MAXC), .CNT_W(CW), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .count     (count),
    .enter     (enter),
    .exit      (exit_p),
    .full      (full),
    .empty     (empty),
    .seq_err   (seq_err),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pass through the gate walks the Gray cycle 00 -> 10 -> 11 -> 01 -> 00
  // (bits swapped for an exit). Stepping forward advances, stepping back
  // retreats, jumping across the cycle is an error.
  logic [1:0] path [4];
  logic [1:0] pipe_m [SYNC];
  int pos_m;
  int dir_m;
  bit err_m;
  int cnt_m;
  bit enter_m, exit_m, serr_m;

  function automatic logic [1:0] code_at(input int dir, input int p);
    logic [1:0] v;
    v = path[p % 4];
    if (dir == 2) v = {v[0], v[1]};
    return v;
  endfunction

  task automatic model_step(input logic [1:0] ab);
    enter_m = 1'b0;
    exit_m  = 1'b0;
    serr_m  = 1'b0;
    if (err_m) begin
      if (ab == 2'b00) err_m = 1'b0;
    end else if (pos_m == 0) begin
      if (ab == 2'b10) begin dir_m = 1; pos_m = 1; end
      else if (ab == 2'b01) begin dir_m = 2; pos_m = 1; end
      else if (ab == 2'b11) begin err_m = 1'b1; serr_m = 1'b1; end
    end else if (ab == code_at(dir_m, pos_m + 1)) begin
      if (pos_m == 3) begin
        pos_m = 0;
        if (dir_m == 1) begin
          enter_m = 1'b1;
          if (cnt_m < MAXC) cnt_m++;
        end else begin
          exit_m = 1'b1;
          if (cnt_m > 0) cnt_m--;
        end
      end else begin
        pos_m++;
      end
    end else if (ab == code_at(dir_m, pos_m - 1)) begin
      pos_m--;
    end else if (ab != code_at(dir_m, pos_m)) begin
      pos_m = 0;
      err_m = 1'b1;
      serr_m = 1'b1;
    end
  endtask

  initial begin
    path[0] = 2'b00; path[1] = 2'b10; path[2] = 2'b11; path[3] = 2'b01;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC; i++) pipe_m[i] = 2'b00;
      pos_m = 0; dir_m = 0; err_m = 1'b0; cnt_m = 0;
      enter_m = 1'b0; exit_m = 1'b0; serr_m = 1'b0;
    end else begin
      model_step(pipe_m[SYNC-1]);
      for (int i = SYNC - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
      pipe_m[0] = {a, b};
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  int n_enter = 0;
  int n_exit  = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    check("count",   int'(count),   cnt_m);
    check("enter",   int'(enter),   int'(enter_m));
    check("exit",    int'(exit_p),  int'(exit_m));
    check("seq_err", int'(seq_err), int'(serr_m));
    check("full",    int'(full),    int'(cnt_m == MAXC));
    check("empty",   int'(empty),   int'(cnt_m == 0));
    if (enter)   n_enter++;
    if (exit_p)  n_exit++;
    if (seq_err) n_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [1:0] ab, input int n);
    @(negedge clk);
    {a, b} = ab;
    repeat (n) @(posedge clk);
  endtask

  task automatic pass_gate(input bit is_exit);
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (is_exit) hold({seq[i][0], seq[i][1]}, 4);
      else hold(seq[i], 4);
    end
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  int e0, x0, s0;

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    reset = 1'b1;

    // single entry
    hold(2'b00, 4);
    pass_gate(1'b0);
    @(negedge clk);
    check("entry_count", int'(count), 1);
    check("entry_pulses", n_enter, 1);
    check("entry_empty", int'(empty), 0);
    check("entry_no_err", n_err, 0);

    // single exit
    hold(2'b00, 4);
    pass_gate(1'b1);
    @(negedge clk);
    check("exit_count", int'(count), 0);
    check("exit_pulses", n_exit, 1);
    check("exit_empty", int'(empty), 1);

    // partial entry that backs out
    e0 = n_enter;
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 4);
    @(negedge clk);
    check("partial_state", int'(dbg_state), int'(IDLE));
    check("partial_no_enter", n_enter - e0, 0);
    check("partial_count", int'(count), 0);

    // fill to capacity and one more
    e0 = n_enter;
    for (int k = 0; k < 26; k++) pass_gate(1'b0);
    @(negedge clk);
    check("fill_count", int'(count), 25);
    check("fill_full", int'(full), 1);
    check("fill_pulses", n_enter - e0, 26);

    // drain and exit once more at empty
    x0 = n_exit;
    for (int k = 0; k < 26; k++) pass_gate(1'b1);
    @(negedge clk);
    check("drain_count", int'(count), 0);
    check("drain_empty", int'(empty), 1);
    check("drain_pulses", n_exit - x0, 26);

    // illegal jump from idle
    s0 = n_err;
    hold(2'b11, 4);
    @(negedge clk);
    check("err_pulse", n_err - s0, 1);
    check("err_state", int'(dbg_state), int'(ERR));
    hold(2'b01, 4);
    @(negedge clk);
    check("err_stuck", int'(dbg_state), int'(ERR));
    check("err_single", n_err - s0, 1);
    hold(2'b00, 4);
    @(negedge clk);
    check("err_recover", int'(dbg_state), int'(IDLE));
    check("err_count", int'(count), 0);

    // reset in the middle of an entry
    for (int k = 0; k < 7; k++) pass_gate(1'b0);
    @(negedge clk);
    check("pre_rst_count", int'(count), 7);
    hold(2'b10, 4);
    hold(2'b11, 4);
    #1;
    check("pre_rst_state", int'(dbg_state), int'(EN2));
    #1;
    reset = 1'b0;
    #0.5;
    check("midrst_count", int'(count), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    #0.5;
    reset = 1'b1;
    e0 = n_enter;
    hold(2'b00, 4);
    @(negedge clk);
    check("post_rst_state", int'(dbg_state), int'(IDLE));
    check("post_rst_count", int'(count), 0);
    check("post_rst_no_enter", n_enter - e0, 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
